// File: rtl/iis_pkg.sv
// Shared types for the I2S receiver: channel and capture-state enums, sample record.
package iis_pkg;

    localparam int IIS_DATA_WIDTH_DFLT = 16;
    localparam int IIS_DATA_WIDTH_MAX  = 32;

    typedef enum logic {
        CH_LEFT  = 1'b0,
        CH_RIGHT = 1'b1
    } iis_chan_e;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_SYNC = 2'd1,
        RX_RUN  = 2'd2
    } iis_rx_state_e;

    typedef struct packed {
        logic [IIS_DATA_WIDTH_MAX-1:0] data;
        iis_chan_e                     chan;
    } iis_sample_t;

endpackage

// File: rtl/iis_rx_fifo.sv
// Sample FIFO for iis_rx: power-of-two depth, push/pop/flush, head is zero when empty.
module iis_rx_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty_o = (r_level == {(AW+1){1'b0}});
    assign full_o  = (r_level == LVL_FULL);
    assign level_o = r_level;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_pop  = pop_i & ~empty_o & ~clear_i;
    assign w_do_push = push_i & ~clear_i & (~full_o | w_do_pop);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_level  <= {(AW+1){1'b0}};
        end else if (clear_i) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_level  <= {(AW+1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + (AW+1)'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_level <= r_level - (AW+1)'(1);
            end else begin
                r_level <= r_level;
            end
        end
    end

    // Storage array
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Head presentation
    always_comb begin
        if (empty_o) begin
            data_o = {WIDTH{1'b0}};
        end else begin
            data_o = r_mem[r_rd_ptr];
        end
    end

endmodule

// File: rtl/iis_rx.sv
// I2S receiver: synchronises SCK/WS/SD, frames words on WS changes, queues samples in a FIFO.
// Optional macro IIS_RX_OVERRUN_CNT_EN adds a saturating overrun counter output.
module iis_rx
    import iis_pkg::*;
#(
    parameter int DATA_WIDTH = IIS_DATA_WIDTH_DFLT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_n,
    input  logic                          en_i,
    input  logic                          clear_i,
    input  logic                          sck_i,
    input  logic                          ws_i,
    input  logic                          sd_i,
    output logic [DATA_WIDTH-1:0]         rx_data_o,
    output logic                          rx_chan_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
`ifdef IIS_RX_OVERRUN_CNT_EN
    output logic [7:0]                    overrun_cnt_o,
`endif
    output logic                          overrun_o
);

    localparam int IW = $clog2(DATA_WIDTH + 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DATA_WIDTH);

    logic                  r_sck_meta, r_sck_sync, r_sck_prev;
    logic                  r_ws_meta, r_ws_sync;
    logic                  r_sd_meta, r_sd_sync;
    iis_rx_state_e         r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_word, w_word_nxt, w_word_bit;
    logic [IW-1:0]         r_idx, w_idx_nxt;
    logic                  r_ws_prev, w_ws_prev_nxt;
    logic                  r_overrun;
    logic                  w_sck_rise, w_ws_change, w_push, w_pop;
    logic                  w_fifo_full, w_fifo_empty;
    logic [DATA_WIDTH:0]   w_fifo_dout;

    assign w_sck_rise  = r_sck_sync & ~r_sck_prev;
    assign w_ws_change = r_ws_sync ^ r_ws_prev;
    assign w_pop       = rx_ready_i & ~w_fifo_empty;

    // Two-flop pad synchronisers plus SCK history for edge detection
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_meta <= 1'b0;
            r_sck_sync <= 1'b0;
            r_sck_prev <= 1'b0;
            r_ws_meta  <= 1'b0;
            r_ws_sync  <= 1'b0;
            r_sd_meta  <= 1'b0;
            r_sd_sync  <= 1'b0;
        end else begin
            r_sck_meta <= sck_i;
            r_sck_sync <= r_sck_meta;
            r_sck_prev <= r_sck_sync;
            r_ws_meta  <= ws_i;
            r_ws_sync  <= r_ws_meta;
            r_sd_meta  <= sd_i;
            r_sd_sync  <= r_sd_meta;
        end
    end

    // Framing state: wait for a WS change before trusting word boundaries
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RX_IDLE: begin
                if (en_i) w_state_nxt = RX_SYNC;
                else      w_state_nxt = RX_IDLE;
            end
            RX_SYNC: begin
                if (!en_i)                         w_state_nxt = RX_IDLE;
                else if (w_sck_rise && w_ws_change) w_state_nxt = RX_RUN;
                else                               w_state_nxt = RX_SYNC;
            end
            RX_RUN: begin
                if (!en_i) w_state_nxt = RX_IDLE;
                else       w_state_nxt = RX_RUN;
            end
            default: w_state_nxt = RX_IDLE;
        endcase
    end

    // Shift-in datapath; the WS-change edge still carries the previous word's LSB slot
    always_comb begin
        w_word_bit    = r_word;
        w_word_nxt    = r_word;
        w_idx_nxt     = r_idx;
        w_ws_prev_nxt = r_ws_prev;
        w_push        = 1'b0;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            if (r_idx == IW'(DATA_WIDTH - 1 - b)) w_word_bit[b] = r_sd_sync;
            else                                  w_word_bit[b] = r_word[b];
        end
        if (!en_i || (r_state == RX_IDLE)) begin
            w_word_nxt    = {DATA_WIDTH{1'b0}};
            w_idx_nxt     = {IW{1'b0}};
            w_ws_prev_nxt = 1'b0;
        end else if (w_sck_rise) begin
            w_ws_prev_nxt = r_ws_sync;
            if (r_state == RX_RUN) begin
                if (w_ws_change) begin
                    w_push     = 1'b1;
                    w_word_nxt = {DATA_WIDTH{1'b0}};
                    w_idx_nxt  = {IW{1'b0}};
                end else begin
                    w_word_nxt = w_word_bit;
                    if (r_idx == IDX_MAX) w_idx_nxt = r_idx;
                    else                  w_idx_nxt = r_idx + IW'(1);
                end
            end else begin
                w_word_nxt = r_word;
                w_idx_nxt  = r_idx;
            end
        end else begin
            w_word_nxt = r_word;
        end
    end

    // Capture state registers and overrun pulse
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RX_IDLE;
            r_word    <= {DATA_WIDTH{1'b0}};
            r_idx     <= {IW{1'b0}};
            r_ws_prev <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_word    <= w_word_nxt;
            r_idx     <= w_idx_nxt;
            r_ws_prev <= w_ws_prev_nxt;
            r_overrun <= w_push & w_fifo_full & ~w_pop & ~clear_i;
        end
    end

    assign overrun_o = r_overrun;

`ifdef IIS_RX_OVERRUN_CNT_EN
    logic [7:0] r_ovr_cnt;

    // Saturating count of dropped samples
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr_cnt <= 8'd0;
        end else if (clear_i) begin
            r_ovr_cnt <= 8'd0;
        end else if (r_overrun && (r_ovr_cnt != 8'hFF)) begin
            r_ovr_cnt <= r_ovr_cnt + 8'd1;
        end
    end

    assign overrun_cnt_o = r_ovr_cnt;
`endif

    iis_rx_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .clear_i (clear_i),
        .data_i  ({w_word_bit, r_ws_prev}),
        .data_o  (w_fifo_dout),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .level_o (level_o)
    );

    assign rx_data_o  = w_fifo_dout[DATA_WIDTH:1];
    assign rx_chan_o  = w_fifo_dout[0];
    assign rx_valid_o = ~w_fifo_empty;

endmodule
